// File: rtl/bsg_packed_cmd_arbiter_pkg.sv
// Shared definitions for the packed command link arbiter and its packers.
//
// Packed command word layout: {write_not_read, addr[22:0], data[7:0]}.
// Provides field position constants, the command struct, the arbiter
// state encoding and a safe ceil-log2 helper for id widths.
package bsg_packed_cmd_arbiter_pkg;

  localparam int cmd_width_gp    = 32;
  localparam int cmd_wnr_bit_gp  = 31;
  localparam int cmd_addr_msb_gp = 30;
  localparam int cmd_addr_lsb_gp = 8;
  localparam int cmd_data_msb_gp = 7;
  localparam int cmd_data_lsb_gp = 0;

  typedef struct packed {
    logic        wnr;
    logic [22:0] addr;
    logic [7:0]  data;
  } bsg_packed_cmd_s;

  typedef enum logic {
    e_idle      = 1'b0,
    e_wait_resp = 1'b1
  } arb_state_e;

  // ceil(log2(n)) that never returns 0, so single-bit ids stay legal.
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_packed_cmd_arbiter_rr_select.sv
// bsg_rr_prio_select: rotating-priority selector.
//
// Ports:
//   req_i     in   num_req_p  request vector
//   ptr_i     in   lg         index holding highest priority this cycle
//   sel_id_o  out  lg         encoded index of the first request at or after ptr_i
//   v_o       out  1          any request present
module bsg_rr_prio_select
  import bsg_packed_cmd_arbiter_pkg::*;
#(
  parameter  int num_req_p     = 2,
  localparam int lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic [num_req_p-1:0]     req_i,
  input  logic [lg_num_req_lp-1:0] ptr_i,
  output logic [lg_num_req_lp-1:0] sel_id_o,
  output logic                     v_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [lg_num_req_lp:0] idx;

  always_comb begin
    idx      = '0;
    sel_id_o = '0;
    v_o      = |req_i;
    // Walk offsets from farthest to nearest so the nearest valid request
    // (lowest offset from ptr_i) is the last one written and wins.
    for (int k = num_req_p - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_i} + (lg_num_req_lp + 1)'(k);
      if (idx >= (lg_num_req_lp + 1)'(num_req_p)) begin
        idx = idx - (lg_num_req_lp + 1)'(num_req_p);
      end
      if (req_i[idx[lg_num_req_lp-1:0]]) begin
        sel_id_o = idx[lg_num_req_lp-1:0];
      end
    end
  end

endmodule

// File: rtl/bsg_packed_cmd_arbiter.sv
// bsg_packed_cmd_arbiter: shares one packed 32-bit command/response link
// between num_req_p requesters with round-robin arbitration. Only one read
// may be outstanding; its response is routed back to the issuing requester.
//
// Ports:
//   clk_i         in   1            clock
//   reset_n_i     in   1            synchronous active-low reset
//   req_data_i    in   N*32         packed commands, requester i at [32*i+:32]
//   req_v_i       in   N            per-requester command valid
//   req_ready_o   out  N            per-requester command ready (one-hot or zero)
//   resp_data_o   out  32           read response data, broadcast
//   resp_v_o      out  N            per-requester response valid (one-hot or zero)
//   resp_ready_i  in   N            per-requester response ready
//   data_o        out  32           granted command toward the link
//   v_o           out  1            command valid toward the link
//   ready_i       in   1            link command ready
//   data_i        in   32           link read-response data
//   v_i           in   1            link read-response valid
//   ready_o       out  1            link read-response ready
module bsg_packed_cmd_arbiter
  import bsg_packed_cmd_arbiter_pkg::*;
#(
  parameter  int num_req_p     = 2,
  localparam int lg_num_req_lp = safe_clog2(num_req_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [num_req_p*32-1:0]   req_data_i,
  input  logic [num_req_p-1:0]      req_v_i,
  output logic [num_req_p-1:0]      req_ready_o,
  output logic [31:0]               resp_data_o,
  output logic [num_req_p-1:0]      resp_v_o,
  input  logic [num_req_p-1:0]      resp_ready_i,
  output logic [31:0]               data_o,
  output logic                      v_o,
  input  logic                      ready_i,
  input  logic [31:0]               data_i,
  input  logic                      v_i,
  output logic                      ready_o
);

  arb_state_e                 state_q, state_d;
  logic [lg_num_req_lp-1:0]   rr_ptr_q, rr_ptr_d;
  logic [lg_num_req_lp-1:0]   owner_q, owner_d;
  logic                       grant_locked_q, grant_locked_d;
  logic [lg_num_req_lp-1:0]   locked_gnt_q, locked_gnt_d;

  logic [lg_num_req_lp-1:0]   rr_sel_id;
  logic                       rr_any_v;
  logic [lg_num_req_lp-1:0]   gnt;
  bsg_packed_cmd_s            granted_cmd;

  bsg_rr_prio_select #(
    .num_req_p (num_req_p)
  ) u_rr_select (
    .req_i    (req_v_i),
    .ptr_i    (rr_ptr_q),
    .sel_id_o (rr_sel_id),
    .v_o      (rr_any_v)
  );

  // A stalled grant is held so the offered command cannot change
  // underneath the link while ready_i is low.
  assign gnt         = grant_locked_q ? locked_gnt_q : rr_sel_id;
  assign granted_cmd = bsg_packed_cmd_s'(req_data_i[32*gnt +: 32]);

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    grant_locked_d = grant_locked_q;
    locked_gnt_d   = locked_gnt_q;

    req_ready_o    = '0;
    resp_data_o    = '0;
    resp_v_o       = '0;
    data_o         = '0;
    v_o            = 1'b0;
    ready_o        = 1'b0;

    // Outputs are forced quiet while reset is held, independent of state.
    if (reset_n_i) begin
      unique case (state_q)
        e_idle: begin
          v_o    = grant_locked_q ? req_v_i[locked_gnt_q] : rr_any_v;
          data_o = granted_cmd;
          if (v_o) begin
            req_ready_o[gnt] = ready_i;
          end

          if (v_o && !ready_i) begin
            grant_locked_d = 1'b1;
            locked_gnt_d   = gnt;
          end else begin
            // Handshake, or the locked requester withdrew: release the lock.
            grant_locked_d = 1'b0;
          end

          if (v_o && ready_i) begin
            rr_ptr_d = (gnt == lg_num_req_lp'(num_req_p - 1))
                     ? '0 : gnt + lg_num_req_lp'(1);
            if (!granted_cmd.wnr) begin
              owner_d = gnt;
              state_d = e_wait_resp;
            end
          end
        end

        e_wait_resp: begin
          resp_data_o       = data_i;
          resp_v_o[owner_q] = v_i;
          ready_o           = resp_ready_i[owner_q];
          if (v_i && ready_o) begin
            state_d = e_idle;
          end
        end

        default: state_d = e_idle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q        <= e_idle;
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      grant_locked_q <= 1'b0;
      locked_gnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      grant_locked_q <= grant_locked_d;
      locked_gnt_q   <= locked_gnt_d;
    end
  end

`ifndef SYNTHESIS
  logic [31:0] locked_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_n_i && state_q == e_idle && v_o && !ready_i && !grant_locked_q) begin
      locked_data_q <= data_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert ($onehot0(req_ready_o))
        else $error("req_ready_o is not one-hot or zero: %b", req_ready_o);
      assert ($onehot0(resp_v_o))
        else $error("resp_v_o is not one-hot or zero: %b", resp_v_o);
      assert (!(grant_locked_q && req_v_i[locked_gnt_q]
                && req_data_i[32*locked_gnt_q +: 32] != locked_data_q))
        else $error("command of locked requester %0d changed while stalled", locked_gnt_q);
      // An unsolicited response is held off by ready_o=0; flag it without stopping.
      assert (!(state_q == e_idle && v_i))
        else $warning("link response valid while no read is outstanding");
    end
  end
`endif

endmodule

// File: doc/bsg_packed_cmd_arbiter.md
Name: bsg_packed_cmd_arbiter

Overview:
- Shares one packed 32-bit command/response link between num_req_p requesters using round-robin arbitration. Each requester is a packer-side channel.
- Command format: {write_not_read, addr[22:0], data[7:0]}. Read responses are 32-bit words.
- Sits between several AXI-lite-to-packed-command converters and the single host-side FIFO pair.
- Allows only one outstanding read at a time and routes its response back to the requester that issued it.

Parameters:
- num_req_p, 2, number of requesters; legal range 2..8.
- lg_num_req_lp, `BSG_SAFE_CLOG2(num_req_p), local parameter: owner-id width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, synchronous, active-low
- req_data_i  in  num_req_p*32  packed commands; requester i occupies bits [32*i+:32]
- req_v_i  in  num_req_p  per-requester command valid
- req_ready_o  out  num_req_p  per-requester command ready (one-hot or zero)
- resp_data_o  out  32  read response data, broadcast to all requesters
- resp_v_o  out  num_req_p  per-requester response valid (one-hot or zero)
- resp_ready_i  in  num_req_p  per-requester response ready
- data_o  out  32  granted command toward the link
- v_o  out  1  command valid toward the link
- ready_i  in  1  link command ready
- data_i  in  32  link read-response data
- v_i  in  1  link read-response valid
- ready_o  out  1  link read-response ready

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on reset_n_i.
- Reset values: state = e_idle, rr_ptr = 0, owner_r = 0.
  - Outputs during reset: v_o=0, req_ready_o=0, resp_v_o=0, ready_o=0, data_o=0.
- States:
  - e_idle: accepts commands.
  - e_wait_resp: a read is outstanding; no commands are granted.
- Arbitration in e_idle:
  - Search req_v_i starting at rr_ptr and wrapping modulo num_req_p. The first valid index is gnt.
  - v_o = |req_v_i. data_o = req_data_i[gnt].
  - req_ready_o[gnt] = ready_i; every other bit is 0.
  - Zero latency: command valid to data_o is combinational. The grant is recomputed each cycle.
  - Grant stability: once v_o is asserted with ready_i low, gnt must not change until the handshake completes.
    - Implement with a grant_locked_r register holding gnt while v_o & ~ready_i.
    - Clear grant_locked_r on the handshake.
- On handshake (v_o & ready_i):
  - rr_ptr <= (gnt+1) mod num_req_p. Wrap: at gnt = num_req_p-1, rr_ptr becomes 0.
  - If data_o[31]=1 (write): stay in e_idle. Writes produce no link response.
  - If data_o[31]=0 (read): owner_r <= gnt, go to e_wait_resp.
- In e_wait_resp:
  - v_o=0 and req_ready_o=0.
  - resp_data_o = data_i. resp_v_o[owner_r] = v_i; all other bits are 0.
  - ready_o = resp_ready_i[owner_r].
  - On v_i & ready_o, return to e_idle. A new grant is possible in the next cycle, not the same one.
- In e_idle: ready_o=0, so unsolicited link responses stall. A simulation-only assertion fires if v_i is high in e_idle.
- Simultaneous events:
  - All requesters valid: served strictly in order rr_ptr, rr_ptr+1, ... Each requester waits at most num_req_p-1 grants.
  - Back-to-back writes from one requester with another valid: alternate.
- Reset mid-operation:
  - An outstanding read is abandoned. The FSM returns to e_idle and rr_ptr returns to 0.
  - Any late response is held off by ready_o=0.
- Simulation-only assertions:
  - req_ready_o and resp_v_o are one-hot or zero.
  - req_data_i[gnt] is stable while a grant is locked.

Decomposition:
- Shared package bp_me_pkg additions:
  - Packed-command field constants: wnr bit 31, address bits 30:8, data bits 7:0.
  - Struct type bsg_packed_cmd_s with fields wnr, addr[22:0], data[7:0], used by this block and its packers.
- One natural sub-module: bsg_rr_prio_select, a rotating-priority one-hot selector with pointer input and encoded output.
  - Alternatively use basejump bsg_arb_round_robin if its hold semantics match the grant-lock rule.

Test Plan:
- Reset with reset_n_i=0 for 3 cycles while req_v_i=2'b11 -> v_o=0, req_ready_o=0 throughout. First grant after reset goes to requester 0.
- Req0 write 0x8000_12AB and req1 write 0x8000_34CD, both held with ready_i=1 -> data_o=0x800012AB then 0x800034CD on consecutive cycles. rr_ptr ends at 0.
- Req1 read 0x0000_5600 accepted; req0 valid during the wait; link returns v_i with data_i=0xDEADBEEF two cycles later -> resp_v_o=2'b10, resp_data_o=0xDEADBEEF. Req0 is granted the cycle after the response handshake.
- ready_i held 0 for 4 cycles while req0 is granted and req1 becomes valid -> data_o stays req0's command, req_ready_o[1]=0. Req0 completes when ready_i=1.
- Response backpressure: resp_ready_i[owner]=0 for 3 cycles with v_i=1 -> ready_o=0, state remains e_wait_resp. Completes on the first cycle resp_ready_i=1.
- Reset asserted during e_wait_resp, then v_i=1 after release -> ready_o=0, resp_v_o=0, assertion fires. New commands are granted normally.
